// File: rtl/r4_sdf_pkg.sv
// Shared definitions for the radix-4 SDF stage sequencer.
// Provides the controller state type, the phase/branch constants and the
// derivations of twiddle stride and group count from frame and segment length.
package r4_sdf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam int unsigned NUM_BRANCH = 4;

  // Last phase that writes a delay branch; the phase after it computes the butterfly.
  localparam logic [1:0] PH_LAST_WR = 2'd2;
  localparam logic [1:0] PH_BF      = 2'd3;

  // Twiddle exponent step between consecutive samples of branch 1.
  function automatic int unsigned tw_stride(input int unsigned n, input int unsigned points);
    return n / (NUM_BRANCH * points);
  endfunction

  // Number of 4-segment groups in one frame.
  function automatic int unsigned num_groups(input int unsigned n, input int unsigned points);
    return n / (NUM_BRANCH * points);
  endfunction

endpackage

// File: rtl/r4_tw_addr_gen.sv
// Twiddle address accumulator for one R4 SDF stage.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   clear    : zero the accumulator (start of a new segment); wins over step
//   step     : add inc (one emitted sample)
//   inc      : per-sample increment, out_sel * stride
//   acc      : current twiddle address, natural ADDR_W-bit wrap (mod N)
module r4_tw_addr_gen #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [ADDR_W-1:0] inc,
  output logic [ADDR_W-1:0] acc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc + inc;
    end
  end

endmodule

// File: rtl/r4_sdf_stage_ctrl.sv
// Sequencer for one radix-4 single-delay-feedback butterfly stage.
// Tracks sample position (segment index, phase, group) and drives the
// datapath controls combinationally from those counters, same cycle as the
// accepted sample. Runs the 3*POINTS-cycle trailing drain on its own.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   in_valid   : upstream sample strobe; in_ready low during drain
//   wr_en      : write sample into delay branch wr_sel (0..2)
//   seg_idx    : position inside the current segment
//   bf_en      : compute butterfly with the current input (phase 3)
//   out_valid  : datapath output valid, out_sel picks butterfly branch 0..3
//   tw_addr    : twiddle ROM address of the emitted sample (0 when idle)
//   frame_done : pulse on the last drained output
//   busy       : controller is not idle
module r4_sdf_stage_ctrl
  import r4_sdf_pkg::*;
#(
  parameter int unsigned POINTS = 16,
  parameter int unsigned N      = 2048,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       wr_en,
  output logic [1:0]                 wr_sel,
  output logic [$clog2(POINTS)-1:0]  seg_idx,
  output logic                       bf_en,
  output logic                       out_valid,
  output logic [1:0]                 out_sel,
  output logic [ADDR_W-1:0]          tw_addr,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int unsigned SEG_W  = $clog2(POINTS);
  localparam int unsigned G      = num_groups(N, POINTS);
  localparam int unsigned GRP_W  = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned STRIDE = tw_stride(N, POINTS);

  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(POINTS - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(G - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        phase;
  logic [SEG_W-1:0]  seg_cnt;
  logic [GRP_W-1:0]  grp_cnt;

  logic              accept;
  logic              advance;
  logic              seg_last;
  logic              grp_last;
  logic              tw_clear;
  logic [ADDR_W-1:0] tw_inc;
  logic [ADDR_W-1:0] tw_acc;

  assign in_ready = (state != ST_DRAIN);
  assign accept   = in_valid & in_ready;
  assign busy     = (state != ST_IDLE);
  assign seg_idx  = seg_cnt;
  assign seg_last = (seg_cnt == SEG_LAST);
  assign grp_last = (grp_cnt == GRP_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    wr_sel     = '0;
    bf_en      = 1'b0;
    out_valid  = 1'b0;
    out_sel    = '0;
    frame_done = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE: begin
        wr_en   = accept;
        wr_sel  = phase;
        advance = accept;
        if (accept) begin
          state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        wr_en   = accept;
        wr_sel  = phase;
        advance = accept;
        if (accept && seg_last && (phase == PH_LAST_WR)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        advance   = accept;
        out_valid = accept;
        if (phase == PH_BF) begin
          bf_en   = accept;
          out_sel = PH_BF;
          if (accept && seg_last && grp_last) begin
            state_nxt = ST_DRAIN;
          end
        end else begin
          // Writing this group's branch while emitting the previous group's.
          wr_en   = accept;
          wr_sel  = phase;
          out_sel = phase;
        end
      end
      ST_DRAIN: begin
        advance   = 1'b1;
        out_valid = 1'b1;
        out_sel   = phase;
        if (seg_last && (phase == PH_LAST_WR)) begin
          frame_done = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Entering DRAIN the counters wrap naturally to group 0 / phase 0;
  // leaving DRAIN they are forced back to zero for the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_cnt <= '0;
      phase   <= '0;
      grp_cnt <= '0;
    end else if (frame_done) begin
      seg_cnt <= '0;
      phase   <= '0;
      grp_cnt <= '0;
    end else if (advance) begin
      seg_cnt <= seg_cnt + SEG_W'(1);
      if (seg_last) begin
        phase <= phase + 2'd1;
        if (phase == PH_BF) begin
          grp_cnt <= grp_last ? '0 : grp_cnt + GRP_W'(1);
        end
      end
    end
  end

  assign tw_clear = advance & seg_last;
  assign tw_inc   = ADDR_W'(out_sel) * ADDR_W'(STRIDE);

  r4_tw_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_tw_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (tw_clear),
    .step  (out_valid),
    .inc   (tw_inc),
    .acc   (tw_acc)
  );

  assign tw_addr = out_valid ? tw_acc : '0;

endmodule

// File: tb/tb_r4_sdf_stage_ctrl.sv
// Self-checking bench for r4_sdf_stage_ctrl (POINTS=4, N=64) plus a
// single-group instance (POINTS=4, N=16).
module tb_r4_sdf_stage_ctrl;

  localparam int P   = 4;
  localparam int NN  = 64;
  localparam int AW  = 6;
  localparam int STR = NN / (4 * P);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [1:0]    seg_idx;
  logic          bf_en;
  logic          out_valid;
  logic [1:0]    out_sel;
  logic [AW-1:0] tw_addr;
  logic          frame_done;
  logic          busy;

  logic          s_in_valid;
  logic          s_in_ready;
  logic          s_wr_en;
  logic [1:0]    s_wr_sel;
  logic [1:0]    s_seg_idx;
  logic          s_bf_en;
  logic          s_out_valid;
  logic [1:0]    s_out_sel;
  logic [3:0]    s_tw_addr;
  logic          s_frame_done;
  logic          s_busy;

  int checks;
  int failures;

  // Reference model: accepted samples in the current frame, drain cycle index
  // (-1 when not draining) and completed frame count.
  int m_k;
  int m_d;
  int m_frames;

  r4_sdf_stage_ctrl #(.POINTS(P), .N(NN), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .seg_idx    (seg_idx),
    .bf_en      (bf_en),
    .out_valid  (out_valid),
    .out_sel    (out_sel),
    .tw_addr    (tw_addr),
    .frame_done (frame_done),
    .busy       (busy)
  );

  r4_sdf_stage_ctrl #(.POINTS(4), .N(16), .ADDR_W(4)) dut_g1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .wr_en      (s_wr_en),
    .wr_sel     (s_wr_sel),
    .seg_idx    (s_seg_idx),
    .bf_en      (s_bf_en),
    .out_valid  (s_out_valid),
    .out_sel    (s_out_sel),
    .tw_addr    (s_tw_addr),
    .frame_done (s_frame_done),
    .busy       (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Compares the current cycle against the frame-position rules, then advances the model.
  task automatic model_check(input bit v);
    int ph, sg, grp, os;
    if (m_d >= 0) begin
      os = m_d / P;
      sg = m_d % P;
      chk("drn_ready", in_ready, 0);
      chk("drn_valid", out_valid, 1);
      chk("drn_sel", out_sel, os);
      chk("drn_seg", seg_idx, sg);
      chk("drn_tw", tw_addr, (os * sg * STR) % NN);
      chk("drn_done", frame_done, (m_d == 3 * P - 1));
      chk("drn_wr", wr_en, 0);
      chk("drn_bf", bf_en, 0);
      chk("drn_busy", busy, 1);
      m_d++;
      if (m_d == 3 * P) begin
        m_d = -1;
        m_k = 0;
        m_frames++;
      end
    end else begin
      chk("m_ready", in_ready, 1);
      chk("m_busy", busy, (m_k > 0));
      chk("m_seg", seg_idx, m_k % P);
      chk("m_done", frame_done, 0);
      if (v) begin
        grp = m_k / (4 * P);
        ph  = (m_k / P) % 4;
        sg  = m_k % P;
        if (ph == 3) begin
          chk("m_bf", bf_en, 1);
          chk("m_wr", wr_en, 0);
          chk("m_valid", out_valid, 1);
          chk("m_sel", out_sel, 3);
          chk("m_tw", tw_addr, (3 * sg * STR) % NN);
        end else begin
          chk("m_bf", bf_en, 0);
          chk("m_wr", wr_en, 1);
          chk("m_wrsel", wr_sel, ph);
          chk("m_valid", out_valid, (grp > 0));
          if (grp > 0) chk("m_sel", out_sel, ph);
          chk("m_tw", tw_addr, (grp > 0) ? (ph * sg * STR) % NN : 0);
        end
        m_k++;
        if (m_k == NN) m_d = 0;
      end else begin
        chk("gap_wr", wr_en, 0);
        chk("gap_bf", bf_en, 0);
        chk("gap_valid", out_valid, 0);
        chk("gap_tw", tw_addr, 0);
      end
    end
  endtask

  task automatic tick(input bit v);
    in_valid = v;
    @(negedge clk);
    model_check(v);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit v;
    bit wr;
    int wsel;
    int seg;
    bit bf;
    bit ov;
    int os;
    int tw;
  } vec_t;

  vec_t tbl[19];
  int   exp_tw[8];

  initial begin
    int  drn, done_at, done_cnt, sc;
    bit  back;

    checks = 0;
    failures = 0;
    m_k = 0;
    m_d = -1;
    m_frames = 0;

    // First frame: FILL with in_valid gaps, then group-0 butterfly phase.
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 2, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 3, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 2, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 1, 2, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 3, 0, 0, 0, 0};
    tbl[9]  = '{1, 1, 1, 3, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 1, 2, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 1, 2, 1, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 2, 2, 0, 0, 0, 0};
    tbl[14] = '{1, 1, 2, 3, 0, 0, 0, 0};
    tbl[15] = '{1, 0, 0, 0, 1, 1, 3, 0};
    tbl[16] = '{1, 0, 0, 1, 1, 1, 3, 12};
    tbl[17] = '{1, 0, 0, 2, 1, 1, 3, 24};
    tbl[18] = '{1, 0, 0, 3, 1, 1, 3, 36};
    exp_tw = '{0, 4, 8, 12, 0, 8, 16, 24};

    rst = 1'b0;
    in_valid = 1'b0;
    s_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr", wr_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_tw", tw_addr, 0);
    chk("rst_seg", seg_idx, 0);
    chk("rst_done", frame_done, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      in_valid = tbl[i].v;
      @(negedge clk);
      chk($sformatf("tbl%0d_wr", i), wr_en, tbl[i].wr);
      if (tbl[i].wr) chk($sformatf("tbl%0d_wrsel", i), wr_sel, tbl[i].wsel);
      chk($sformatf("tbl%0d_seg", i), seg_idx, tbl[i].seg);
      chk($sformatf("tbl%0d_bf", i), bf_en, tbl[i].bf);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ov);
      if (tbl[i].ov) chk($sformatf("tbl%0d_sel", i), out_sel, tbl[i].os);
      chk($sformatf("tbl%0d_tw", i), tw_addr, tbl[i].tw);
      model_check(tbl[i].v);
      @(posedge clk);
      #1;
    end

    // Group 1: phase 0 (out_sel 0), then phases 1 and 2 twiddle ramps.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (i >= 4) chk($sformatf("g1_tw%0d", i), tw_addr, exp_tw[i - 4]);
      model_check(1'b1);
      @(posedge clk);
      #1;
    end

    while (m_k != 0 && m_d < 0) tick(1'b1);

    // Drain with in_valid held high; then the first accept starts a new frame.
    drn = 0;
    done_at = -1;
    done_cnt = 0;
    back = 1'b0;
    for (int c = 0; c < 20 && !back; c++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        back = 1'b1;
        chk("post_busy", busy, 0);
        chk("post_wr", wr_en, 1);
        chk("post_wrsel", wr_sel, 0);
        chk("post_seg", seg_idx, 0);
      end else begin
        if (out_valid) drn++;
        if (frame_done) begin
          done_cnt++;
          done_at = drn;
        end
      end
      model_check(1'b1);
      @(posedge clk);
      #1;
    end
    chk("drain_exit", back, 1);
    chk("drain_len", drn, 12);
    chk("done_cnt", done_cnt, 1);
    chk("done_pos", done_at, 12);

    // Reset mid-frame at sample 30.
    while (m_k < 30) tick(1'b1);
    in_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk("mrst_ready", in_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_seg", seg_idx, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_tw", tw_addr, 0);
    chk("mrst_done", frame_done, 0);
    @(negedge clk);
    chk("mrst_done2", frame_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_k = 0;
    m_d = -1;

    repeat (16) tick(1'b1);

    // Randomized in_valid until two more frames complete.
    sc = m_frames + 2;
    for (int c = 0; c < 3000 && m_frames < sc; c++) begin
      tick($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;

    // Single-group instance: FILL, RUN phase 3, DRAIN.
    for (int c = 0; c < 29; c++) begin
      s_in_valid = 1'b1;
      @(negedge clk);
      if (c < 12) begin
        chk($sformatf("g1f%0d_wr", c), s_wr_en, 1);
        chk($sformatf("g1f%0d_wrsel", c), s_wr_sel, c / 4);
        chk($sformatf("g1f%0d_valid", c), s_out_valid, 0);
      end else if (c < 16) begin
        chk($sformatf("g1r%0d_bf", c), s_bf_en, 1);
        chk($sformatf("g1r%0d_sel", c), s_out_sel, 3);
        chk($sformatf("g1r%0d_tw", c), s_tw_addr, 3 * (c - 12));
      end else if (c < 28) begin
        chk($sformatf("g1d%0d_ready", c), s_in_ready, 0);
        chk($sformatf("g1d%0d_valid", c), s_out_valid, 1);
        chk($sformatf("g1d%0d_sel", c), s_out_sel, (c - 16) / 4);
        chk($sformatf("g1d%0d_tw", c), s_tw_addr, ((c - 16) / 4) * ((c - 16) % 4));
        chk($sformatf("g1d%0d_done", c), s_frame_done, (c == 27));
      end else begin
        chk("g1_idle_busy", s_busy, 0);
        chk("g1_idle_ready", s_in_ready, 1);
      end
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
